mem_result_checker: RTL and testbench
=====================================

# mem_result_checker

Self-checking sequencer for the matrix-processor environment. On the stop opcode (or a manual start) it walks a table of up to DEPTH expected memory words, reads each location from main memory over the shared read bus, and compares it with the expected value, full width or low 16 bits. It reports pass/fail, a mismatch count and the first failing index. It generalises the fixed 12-location end-of-program check into a parametrised, programmable, cycle-accurate checker.

## Interface
- DATA_W, 256, width of memory words and expected values
- ADDR_W, 16, memory address width
- DEPTH, 16, number of expected-table entries (≥2)
- BASE_ADDR, 0, address checked by entry 0; entry i checks BASE_ADDR+i
- RD_LAT, 1, cycles from nRead low to rd_data valid (≥1)
- STOP_OPCODE, 32'hff000000, value of InstructDataOut[31:0] that triggers a check
- Clk  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- InstructDataOut  in  DATA_W  instruction bus; only [31:0] is used
- start  in  1  manual trigger, single-cycle pulse
- exp_we  in  1  expected-table write strobe
- exp_idx  in  $clog2(DEPTH)  table entry written
- exp_data  in  DATA_W  expected value
- exp_low16  in  1  1: compare [15:0] only; 0: compare full width
- exp_valid  in  1  1: entry checked; 0: entry skipped
- address  out  ADDR_W  read address
- nRead  out  1  active-low read strobe
- rd_data  in  DATA_W  memory read data
- busy  out  1  check in progress
- done  out  1  check complete; held until next trigger
- fail  out  1  at least one mismatch
- fail_count  out  $clog2(DEPTH+1)  mismatches in the last run
- first_fail_idx  out  $clog2(DEPTH)  lowest failing entry; 0 if none

## Operation
- Reset values: address=0, nRead=1, busy=0, done=0, fail=0, fail_count=0, first_fail_idx=0. All table valid bits are cleared; table data is not reset.
- Trigger: rising edge of (InstructDataOut[31:0]==STOP_OPCODE) or start=1, sampled in IDLE or DONE.
  - Triggers in other states are ignored.
  - A level held at STOP_OPCODE triggers once.
- Table writes are accepted only when busy=0; writes while busy are dropped.
- FSM states: IDLE, ISSUE, WAIT, COMPARE, DONE.
  - Trigger → ISSUE, with idx=0, fail_count=0, first_fail_idx=0, fail=0, done=0, busy=1.
  - ISSUE, entry valid: drive address=BASE_ADDR+idx and nRead=0 for exactly one cycle → WAIT.
  - ISSUE, entry invalid: no read is issued. Advance idx, or go to DONE if idx==DEPTH-1.
  - WAIT: count RD_LAT-1 further cycles with nRead=1 → COMPARE.
  - COMPARE: sample rd_data and compare under the entry's mask.
    - On mismatch: increment fail_count and set fail.
    - On the first mismatch of the run: record idx in first_fail_idx.
    - Then advance idx → ISSUE, or → DONE after idx==DEPTH-1.
  - DONE: busy=0, done=1. A new trigger restarts the run.
- Address arithmetic is modulo 2^ADDR_W; BASE_ADDR+i wraps silently.
- If no entries are valid, the run completes with fail=0 and fail_count=0.

## Timing
- Trigger in cycle t → busy=1 and first nRead low at t+1.
- Valid entry costs RD_LAT+2 cycles (ISSUE, WAIT×RD_LAT, COMPARE); invalid entry costs 1 cycle.
- rd_data is sampled on the edge exactly RD_LAT cycles after the nRead-low cycle.
- done rises, and busy falls, on the edge after the last entry's COMPARE or skip.
- fail, fail_count and first_fail_idx update on the COMPARE edge and are stable while done=1.
- Reset asserted mid-run forces all outputs to reset values immediately. No partial result survives.

## Configuration
- STICKY_FAIL_EN defined:
  - fail is not cleared by a new trigger; only nReset clears it.
  - fail_count and first_fail_idx still reset per run.
- STICKY_FAIL_EN undefined: fail reflects only the most recent run.

## Test plan
- Reset mid-run: assert nReset during WAIT of entry 1 → all outputs at reset values; a following trigger with all valid bits cleared → done after DEPTH cycles, fail=0.
- All pass: load entries 0–11 valid, memory matches, RD_LAT=1 → done 36 cycles after trigger, fail=0, fail_count=0; nRead pulses 12 times at addresses 0–11.
- Low-16 mask: entry 10 exp_low16=1, expected 16'h0024, memory 256'h…ffff0024 → pass. The same entry with exp_low16=0 → fail=1, first_fail_idx=10.
- Multiple mismatches: corrupt entries 2 and 7 → fail_count=2, first_fail_idx=2. Writes issued while busy=1 do not alter the table.
- Stop-opcode trigger: hold InstructDataOut[31:0]=32'hff000000 for 50 cycles → exactly one run. A start pulse while busy → ignored.
- Sticky fail: first run fails, second run passes → fail=0 without STICKY_FAIL_EN; fail=1 with it (fail_count=0 in both cases).

Source files
------------

// File: rtl/mem_result_checker_if.sv
// Shared main-memory read bus between the result checker (master) and main memory (slave).
interface mem_result_checker_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              nRead;
  logic [DATA_W-1:0] rd_data;

  modport master (output address, output nRead, input rd_data);
  modport slave  (input address, input nRead, output rd_data);
endinterface

// File: rtl/mem_result_checker.sv
// Self-checking sequencer: walks a programmable table of expected words and compares them with main memory.
// Optional feature macro STICKY_FAIL_EN: fail stays set across runs until nReset.
module mem_result_checker #(
  parameter int          DATA_W      = 256,
  parameter int          ADDR_W      = 16,
  parameter int          DEPTH       = 16,
  parameter int          BASE_ADDR   = 0,
  parameter int          RD_LAT      = 1,
  parameter logic [31:0] STOP_OPCODE = 32'hff000000,
  localparam int         IDX_W       = $clog2(DEPTH),
  localparam int         CNT_W       = $clog2(DEPTH + 1),
  localparam int         WAIT_W      = $clog2(RD_LAT + 1)
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic [DATA_W-1:0]    InstructDataOut,
  input  logic                 start,
  input  logic                 exp_we,
  input  logic [IDX_W-1:0]     exp_idx,
  input  logic [DATA_W-1:0]    exp_data,
  input  logic                 exp_low16,
  input  logic                 exp_valid,
  mem_result_checker_if.master memBus,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CNT_W-1:0]     fail_count,
  output logic [IDX_W-1:0]     first_fail_idx
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMPARE, DONE} stateT;

  stateT             state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nextIdx;
  logic [WAIT_W-1:0] waitCnt;
  logic [DATA_W-1:0] rdQ;
  logic [ADDR_W-1:0] addrQ;
  logic              nReadQ;
  logic              stopHit;
  logic              stopHitQ;
  logic              trigger;
  logic              lastIdx;
  logic              mismatch;
  logic              tableWrite;
  logic              unusedInstrHi;

  logic [DATA_W-1:0] expData [DEPTH];
  logic [DEPTH-1:0]  expLow16;
  logic [DEPTH-1:0]  expValid;

  assign unusedInstrHi  = ^InstructDataOut[DATA_W-1:32];
  assign stopHit        = (InstructDataOut[31:0] == STOP_OPCODE);
  assign trigger        = (stopHit && !stopHitQ) || start;
  assign nextIdx        = idx + IDX_W'(1);
  assign lastIdx        = (idx == IDX_W'(DEPTH - 1));
  assign tableWrite     = exp_we && !busy && (int'(exp_idx) < DEPTH);
  assign memBus.address = addrQ;
  assign memBus.nRead   = nReadQ;

  always_comb begin
    mismatch = 1'b0;
    if (expLow16[idx]) begin
      mismatch = (rdQ[15:0] != expData[idx][15:0]);
    end else begin
      mismatch = (rdQ != expData[idx]);
    end
  end

  // Table contents have no reset; only the valid bits must come up cleared.
  always_ff @(posedge Clk) begin
    if (tableWrite) begin
      expData[exp_idx]  <= exp_data;
      expLow16[exp_idx] <= exp_low16;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      expValid <= '0;
    end else if (tableWrite) begin
      expValid[exp_idx] <= exp_valid;
    end
  end

  // The read for an entry is committed on the edge that selects it, keeping address/nRead
  // registered; ISSUE then follows whichever nRead level was committed for the current entry.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state          <= IDLE;
      idx            <= '0;
      waitCnt        <= '0;
      rdQ            <= '0;
      addrQ          <= '0;
      nReadQ         <= 1'b1;
      stopHitQ       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      stopHitQ <= stopHit;
      nReadQ   <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (trigger) begin
            state          <= ISSUE;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
`ifndef STICKY_FAIL_EN
            fail           <= 1'b0;
`endif
            if (expValid[0]) begin
              nReadQ <= 1'b0;
              addrQ  <= ADDR_W'(BASE_ADDR);
            end
          end
        end
        ISSUE: begin
          if (!nReadQ) begin
            state   <= WAIT;
            waitCnt <= '0;
          end else if (lastIdx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= nextIdx;
            if (expValid[nextIdx]) begin
              nReadQ <= 1'b0;
              addrQ  <= ADDR_W'(BASE_ADDR) + ADDR_W'(nextIdx);
            end
          end
        end
        WAIT: begin
          if (int'(waitCnt) == RD_LAT - 1) begin
            rdQ   <= memBus.rd_data;
            state <= COMPARE;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        COMPARE: begin
          if (mismatch) begin
            fail_count <= fail_count + CNT_W'(1);
            fail       <= 1'b1;
            if (fail_count == '0) begin
              first_fail_idx <= idx;
            end
          end
          if (lastIdx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ISSUE;
            idx   <= nextIdx;
            if (expValid[nextIdx]) begin
              nReadQ <= 1'b0;
              addrQ  <= ADDR_W'(BASE_ADDR) + ADDR_W'(nextIdx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_result_checker.sv
// Bench for mem_result_checker: vector table, hand-written corner sequences and randomized runs vs a reference model.
module tb_mem_result_checker;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 12;
  localparam int RD_LAT = 1;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] STOP = 32'hff000000;

  typedef struct {
    logic [DEPTH-1:0] validMask;
    logic [DEPTH-1:0] low16Mask;
    logic [DEPTH-1:0] corruptHiMask;
    logic [DEPTH-1:0] corruptLoMask;
    int               expCount;
    int               expFirst;
    int               expCycles;
  } vecT;

  logic              clk;
  logic              nReset;
  logic [DATA_W-1:0] instr;
  logic              start;
  logic              exp_we;
  logic [IDX_W-1:0]  exp_idx;
  logic [DATA_W-1:0] exp_data;
  logic              exp_low16;
  logic              exp_valid;
  logic              busy;
  logic              done;
  logic              fail;
  logic [CNT_W-1:0]  fail_count;
  logic [IDX_W-1:0]  first_fail_idx;

  int total;
  int bad;
  bit stickyFail;

  logic [DATA_W-1:0] mem   [16];
  logic [DATA_W-1:0] tData [DEPTH];
  logic [DEPTH-1:0]  tLow;
  logic [DEPTH-1:0]  tValid;
  logic [ADDR_W-1:0] issued [$];

  mem_result_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_result_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0),
    .RD_LAT(RD_LAT), .STOP_OPCODE(STOP)
  ) dut (
    .Clk(clk), .nReset(nReset), .InstructDataOut(instr), .start(start),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
    .exp_low16(exp_low16), .exp_valid(exp_valid), .memBus(bus),
    .busy(busy), .done(done), .fail(fail), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory returns data for exactly one cycle after the nRead-low cycle, noise otherwise.
  always @(posedge clk) begin
    if (bus.nRead == 1'b0) begin
      bus.rd_data <= mem[bus.address[3:0]];
      issued.push_back(bus.address);
    end else begin
      bus.rd_data <= {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
    end
  end

  function automatic logic [DATA_W-1:0] pattern(input int i);
    logic [31:0] w;
    w = 32'(i) * 32'h01010101 ^ 32'h5a3c0f00;
    return {8{w}};
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic loadEntry(input int i, input logic [DATA_W-1:0] d, input logic lo,
                           input logic v, input bit track);
    @(negedge clk);
    exp_we    = 1'b1;
    exp_idx   = IDX_W'(i);
    exp_data  = d;
    exp_low16 = lo;
    exp_valid = v;
    @(negedge clk);
    exp_we = 1'b0;
    if (track) begin
      tData[i] = d;
      tLow[i]  = lo;
      tValid[i] = v;
    end
  endtask

  task automatic setupVector(input vecT v);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = pattern(i);
      mem[i] = w;
      if (v.corruptHiMask[i]) mem[i][200] = ~mem[i][200];
      if (v.corruptLoMask[i]) mem[i][3] = ~mem[i][3];
      loadEntry(i, w, v.low16Mask[i], v.validMask[i], 1'b1);
    end
  endtask

  task automatic waitDone(inout int cycles);
    while (done !== 1'b1 && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic applyStimulus(output int cycles);
    issued.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyAfterTrigger", busy, 1);
    checkOutput("doneClearedOnTrigger", done, 0);
    cycles = 0;
    waitDone(cycles);
  endtask

  task automatic checkRun(input int cycles, input int eCycles, input int eCount,
                          input int eFirst, input logic [DEPTH-1:0] vMask);
    bit expFail;
    int k;
    stickyFail = stickyFail | (eCount != 0);
`ifdef STICKY_FAIL_EN
    expFail = stickyFail;
`else
    expFail = (eCount != 0);
`endif
    checkOutput("cycles", cycles, eCycles);
    checkOutput("done", done, 1);
    checkOutput("busyAtDone", busy, 0);
    checkOutput("failCount", fail_count, eCount);
    checkOutput("firstFailIdx", first_fail_idx, eFirst);
    checkOutput("fail", fail, expFail);
    k = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vMask[i]) begin
        if (k < issued.size()) checkOutput("readAddr", issued[k], i);
        k++;
      end
    end
    checkOutput("readCount", issued.size(), k);
  endtask

  task automatic checkResetState();
    checkOutput("rstAddress", bus.address, 0);
    checkOutput("rstNRead", bus.nRead, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstFail", fail, 0);
    checkOutput("rstFailCount", fail_count, 0);
    checkOutput("rstFirstFail", first_fail_idx, 0);
  endtask

  // Reference model: cost and outcome of a run derived directly from the table and memory contents.
  task automatic modelRun(output int cnt, output int first, output int cycles);
    bit eq;
    cnt = 0;
    first = 0;
    cycles = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tValid[i]) begin
        cycles += RD_LAT + 2;
        eq = tLow[i] ? (mem[i][15:0] == tData[i][15:0]) : (mem[i] == tData[i]);
        if (!eq) begin
          if (cnt == 0) first = i;
          cnt++;
        end
      end else begin
        cycles += 1;
      end
    end
  endtask

  vecT vecs [10];
  int  cycles;
  int  mCnt, mFirst, mCycles;
  int  rises, doneAt;
  bit  prevBusy;

  initial begin
    total = 0;
    bad = 0;
    stickyFail = 0;
    nReset = 1'b0;
    instr = '0;
    start = 1'b0;
    exp_we = 1'b0;
    exp_idx = '0;
    exp_data = '0;
    exp_low16 = 1'b0;
    exp_valid = 1'b0;
    tValid = '0;
    tLow = '0;
    for (int i = 0; i < 16; i++) mem[i] = pattern(i);

    vecs[0] = '{12'hfff, 12'h000, 12'h000, 12'h000, 0, 0, 36};
    vecs[1] = '{12'hfff, 12'h000, 12'h400, 12'h000, 1, 10, 36};
    vecs[2] = '{12'hfff, 12'h400, 12'h400, 12'h000, 0, 0, 36};
    vecs[3] = '{12'hfff, 12'h000, 12'h084, 12'h000, 2, 2, 36};
    vecs[4] = '{12'hfff, 12'h400, 12'h000, 12'h400, 1, 10, 36};
    vecs[5] = '{12'h000, 12'h000, 12'hfff, 12'h000, 0, 0, 12};
    vecs[6] = '{12'h801, 12'h000, 12'h000, 12'h800, 1, 11, 16};
    vecs[7] = '{12'hfff, 12'h000, 12'h000, 12'hfff, 12, 0, 36};
    vecs[8] = '{12'h020, 12'h000, 12'h060, 12'h000, 1, 5, 14};
    vecs[9] = '{12'h555, 12'h555, 12'h555, 12'h000, 0, 0, 24};

    repeat (3) @(negedge clk);
    checkResetState();
    nReset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      setupVector(vecs[v]);
      applyStimulus(cycles);
      checkRun(cycles, vecs[v].expCycles, vecs[v].expCount, vecs[v].expFirst, vecs[v].validMask);
    end

    // Low-16 mask: upper bits differ but the compared half matches.
    setupVector(vecs[0]);
    mem[10] = {{224{1'b1}}, 32'hffff0024};
    loadEntry(10, 256'h0024, 1'b1, 1'b1, 1'b1);
    applyStimulus(cycles);
    checkRun(cycles, 36, 0, 0, 12'hfff);
    loadEntry(10, 256'h0024, 1'b0, 1'b1, 1'b1);
    applyStimulus(cycles);
    checkRun(cycles, 36, 1, 10, 12'hfff);

    // Writes while busy must be dropped, both during this run and for the next one.
    setupVector(vecs[0]);
    issued.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_we = 1'b1;
    exp_idx = IDX_W'(3);
    exp_data = '1;
    exp_low16 = 1'b0;
    exp_valid = 1'b1;
    @(negedge clk);
    exp_idx = IDX_W'(4);
    exp_valid = 1'b0;
    @(negedge clk);
    exp_we = 1'b0;
    cycles = 2;
    waitDone(cycles);
    checkRun(cycles, 36, 0, 0, 12'hfff);
    applyStimulus(cycles);
    checkRun(cycles, 36, 0, 0, 12'hfff);

    // Stop opcode held for 50 cycles runs once; a start pulse while busy is ignored.
    issued.delete();
    @(negedge clk);
    instr[31:0] = STOP;
    instr[DATA_W-1:32] = {7{32'hdeadbeef}};
    prevBusy = busy;
    rises = 0;
    doneAt = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (busy && !prevBusy) rises++;
      prevBusy = busy;
      if (done && doneAt < 0) doneAt = c;
    end
    start = 1'b0;
    instr = '0;
    checkOutput("stopRunCount", rises, 1);
    checkOutput("stopDoneCycle", doneAt, 36);
    checkOutput("stopReadCount", issued.size(), 12);
    checkOutput("stopDoneHeld", done, 1);
    checkOutput("stopFailCount", fail_count, 0);

    // Reset during WAIT of entry 1, then a run over an empty table.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    nReset = 1'b0;
    #1;
    checkResetState();
    @(negedge clk);
    nReset = 1'b1;
    tValid = '0;
    stickyFail = 0;
    applyStimulus(cycles);
    checkRun(cycles, DEPTH, 0, 0, '0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [DATA_W-1:0] d;
        int mode;
        int pos;
        for (int b = 0; b < 8; b++) d[b*32 +: 32] = $urandom;
        mem[i] = d;
        mode = $urandom_range(0, 3);
        if (mode == 2) begin
          pos = $urandom_range(255, 16);
          mem[i][pos] = ~mem[i][pos];
        end else if (mode == 3) begin
          pos = $urandom_range(15, 0);
          mem[i][pos] = ~mem[i][pos];
        end
        loadEntry(i, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b1);
      end
      modelRun(mCnt, mFirst, mCycles);
      applyStimulus(cycles);
      checkRun(cycles, mCycles, mCnt, mFirst, tValid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
